// File: rtl/vga_pkg.sv
// Shared timing constants and pixel format for the frame buffer VGA read path.
package vga_pkg;
  localparam int CLK_DIV   = 4;
  localparam int H_VIS     = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VIS     = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int ADDR_W    = 19;
  localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FB_PIXELS = H_VIS * V_VIS;
  localparam int CNT_W     = 10;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;
endpackage

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters and sync/visible decode for one VGA mode.
module vga_timing #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic visible,
  output logic hs_n,
  output logic vs_n,
  output logic vblank,
  output logic frame_wrap,
  output logic frame_start
);
  import vga_pkg::*;

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int H_LAST = H_VIS + H_FP + H_SYNC + H_BP - 1;
  localparam int V_LAST = V_VIS + V_FP + V_SYNC + V_BP - 1;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             frame_start_q, frame_start_d;
  logic             h_last, v_last;

  always_comb begin
    tick       = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    h_last     = (h_cnt_q == CNT_W'(H_LAST));
    v_last     = (v_cnt_q == CNT_W'(V_LAST));
    frame_wrap = tick && h_last && v_last;
    div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    if (tick) begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end else begin
      h_cnt_d = h_cnt_q;
    end
    // Pulse lasts exactly the clk after the wrapping tick.
    frame_start_d = frame_wrap;
    visible = (h_cnt_q < CNT_W'(H_VIS)) && (v_cnt_q < CNT_W'(V_VIS));
    hs_n    = !((h_cnt_q >= CNT_W'(HS_BEG)) && (h_cnt_q <= CNT_W'(HS_END)));
    vs_n    = !((v_cnt_q >= CNT_W'(VS_BEG)) && (v_cnt_q <= CNT_W'(VS_END)));
    vblank  = (v_cnt_q >= CNT_W'(V_VIS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q     <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      frame_start_q <= 1'b0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;
endmodule

// File: rtl/vga_fb_reader.sv
// Frame buffer read side: raster-order address generation plus a one-tick
// RGB/sync output pipeline aligned to the RAM read latency.
module vga_fb_reader #(
  parameter int CLK_DIV = vga_pkg::CLK_DIV,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP,
  parameter int ADDR_W  = vga_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       doutB,
  output logic [ADDR_W-1:0] addrB,
  output logic [3:0]        vga_r,
  output logic [3:0]        vga_g,
  output logic [3:0]        vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start,
  output logic              in_vblank
);
  import vga_pkg::*;

  logic tick, visible, hs_n, vs_n, vblank, frame_wrap;

  vga_timing #(
    .CLK_DIV(CLK_DIV), .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_tim (
    .clk(clk), .reset(reset), .tick(tick), .visible(visible), .hs_n(hs_n),
    .vs_n(vs_n), .vblank(vblank), .frame_wrap(frame_wrap), .frame_start(frame_start)
  );

  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [ADDR_W-1:0] addr_b_q, addr_b_d;
  logic              vis_p_q, vis_p_d, hs_p_q, hs_p_d, vs_p_q, vs_p_d;
  pixel_t            rgb_q, rgb_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;
  logic              in_vblank_q, in_vblank_d;

  always_comb begin
    pix_addr_d  = pix_addr_q;
    addr_b_d    = addr_b_q;
    vis_p_d     = vis_p_q;
    hs_p_d      = hs_p_q;
    vs_p_d      = vs_p_q;
    rgb_d       = rgb_q;
    hsync_d     = hsync_q;
    vsync_d     = vsync_q;
    in_vblank_d = in_vblank_q;
    if (tick) begin
      // Stage 1: doutB now reflects the address issued on the previous tick.
      rgb_d   = vis_p_q ? pixel_t'(doutB) : pixel_t'(12'h000);
      hsync_d = hs_p_q;
      vsync_d = vs_p_q;
      // Stage 0
      vis_p_d     = visible;
      hs_p_d      = hs_n;
      vs_p_d      = vs_n;
      in_vblank_d = vblank;
      if (frame_wrap) begin
        pix_addr_d = '0;
      end else if (visible) begin
        addr_b_d   = pix_addr_q;
        pix_addr_d = pix_addr_q + ADDR_W'(1);
      end else begin
        pix_addr_d = pix_addr_q;
      end
    end else begin
      rgb_d = rgb_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pix_addr_q  <= '0;
      addr_b_q    <= '0;
      vis_p_q     <= 1'b0;
      hs_p_q      <= 1'b1;
      vs_p_q      <= 1'b1;
      rgb_q       <= '0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      in_vblank_q <= 1'b0;
    end else begin
      pix_addr_q  <= pix_addr_d;
      addr_b_q    <= addr_b_d;
      vis_p_q     <= vis_p_d;
      hs_p_q      <= hs_p_d;
      vs_p_q      <= vs_p_d;
      rgb_q       <= rgb_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      in_vblank_q <= in_vblank_d;
    end
  end

  assign addrB     = addr_b_q;
  assign vga_r     = rgb_q.r;
  assign vga_g     = rgb_q.g;
  assign vga_b     = rgb_q.b;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign in_vblank = in_vblank_q;
endmodule
